// File: rtl/syn_sram_arb_if.sv
// Client and SRAM-driver bundle for the vcortex SRAM arbiter.
// The slave view is the arbiter; the master view is clients plus driver.
interface syn_sram_arb_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 16
);
    logic              vga_req;
    logic [ADDR_W-1:0] vga_addr;
    logic              vga_gnt;
    logic              vga_rd_valid;
    logic [DATA_W-1:0] vga_rd_data;
    logic              gpu_req;
    logic              gpu_wr;
    logic [ADDR_W-1:0] gpu_addr;
    logic [DATA_W-1:0] gpu_wr_data;
    logic              gpu_gnt;
    logic              gpu_rd_valid;
    logic [DATA_W-1:0] gpu_rd_data;
    logic              sram_req;
    logic              sram_wr;
    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_wr_data;
    logic              sram_ready;
    logic              sram_rd_valid;
    logic [DATA_W-1:0] sram_rd_data;

    modport slave (
        input  vga_req, vga_addr,
        input  gpu_req, gpu_wr, gpu_addr, gpu_wr_data,
        input  sram_ready, sram_rd_valid, sram_rd_data,
        output vga_gnt, vga_rd_valid, vga_rd_data,
        output gpu_gnt, gpu_rd_valid, gpu_rd_data,
        output sram_req, sram_wr, sram_addr, sram_wr_data
    );

    modport master (
        output vga_req, vga_addr,
        output gpu_req, gpu_wr, gpu_addr, gpu_wr_data,
        output sram_ready, sram_rd_valid, sram_rd_data,
        input  vga_gnt, vga_rd_valid, vga_rd_data,
        input  gpu_gnt, gpu_rd_valid, gpu_rd_data,
        input  sram_req, sram_wr, sram_addr, sram_wr_data
    );
endinterface

// File: rtl/syn_sram_arb.sv
// Two-client SRAM arbiter: VGA fixed priority, GPU starvation guard,
// in-order tag FIFO steering read returns back to the issuing client.
module syn_sram_arb #(
    parameter int ADDR_W     = 18,
    parameter int DATA_W     = 16,
    parameter int MAX_OUTST  = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic           clk_ir,
    input  logic           rst_sync_l,
    syn_sram_arb_if.slave  bus
);
    localparam int PTR_W = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;
    localparam int CNT_W = $clog2(MAX_OUTST + 1);
    localparam int ST_W  = $clog2(STARVE_MAX + 1);

    logic [MAX_OUTST-1:0] tag_q, tag_d;
    logic [PTR_W-1:0]     wptr_q, wptr_d;
    logic [PTR_W-1:0]     rptr_q, rptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ST_W-1:0]      starve_q, starve_d;
    logic                 vga_v_q, vga_v_d;
    logic                 gpu_v_q, gpu_v_d;
    logic [DATA_W-1:0]    vga_data_q, vga_data_d;
    logic [DATA_W-1:0]    gpu_data_q, gpu_data_d;
    logic                 err_q, err_d;

    logic force_gpu, sel_vga, sel_gpu, sel_rd, block;
    logic vga_gnt, gpu_gnt, push, pop, pop_tag;

    // Outputs are held at 0 while reset is asserted, even with live requests.
    always_comb begin
        force_gpu = bus.gpu_req && (starve_q == ST_W'(STARVE_MAX));
        sel_vga   = rst_sync_l && bus.vga_req && !force_gpu;
        sel_gpu   = rst_sync_l && !sel_vga && bus.gpu_req;
        sel_rd    = sel_vga || (sel_gpu && !bus.gpu_wr);
        block     = sel_rd && (cnt_q == CNT_W'(MAX_OUTST));
        vga_gnt   = sel_vga && bus.sram_ready && !block;
        gpu_gnt   = sel_gpu && bus.sram_ready && !block;
        push      = vga_gnt || (gpu_gnt && !bus.gpu_wr);
        pop       = bus.sram_rd_valid && (cnt_q != '0);
        pop_tag   = tag_q[rptr_q];
    end

    assign bus.vga_gnt      = vga_gnt;
    assign bus.gpu_gnt      = gpu_gnt;
    assign bus.sram_req     = (sel_vga || sel_gpu) && !block;
    assign bus.sram_wr      = sel_gpu && bus.gpu_wr;
    assign bus.sram_addr    = sel_vga ? bus.vga_addr :
                              sel_gpu ? bus.gpu_addr : '0;
    assign bus.sram_wr_data = (sel_gpu && bus.gpu_wr) ? bus.gpu_wr_data : '0;
    assign bus.vga_rd_valid = vga_v_q;
    assign bus.vga_rd_data  = vga_data_q;
    assign bus.gpu_rd_valid = gpu_v_q;
    assign bus.gpu_rd_data  = gpu_data_q;

    always_comb begin
        tag_d      = tag_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        cnt_d      = cnt_q;
        starve_d   = starve_q;
        vga_v_d    = 1'b0;
        gpu_v_d    = 1'b0;
        vga_data_d = vga_data_q;
        gpu_data_d = gpu_data_q;
        err_d      = err_q;

        if (push) begin
            tag_d[wptr_q] = gpu_gnt;
            wptr_d        = wptr_q + 1'b1;
        end
        if (pop) begin
            rptr_d = rptr_q + 1'b1;
            if (pop_tag) begin
                gpu_v_d    = 1'b1;
                gpu_data_d = bus.sram_rd_data;
            end else begin
                vga_v_d    = 1'b1;
                vga_data_d = bus.sram_rd_data;
            end
        end
        // Returns with nothing outstanding are dropped but remembered.
        if (bus.sram_rd_valid && !pop)
            err_d = 1'b1;

        unique case ({push, pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase

        if (!bus.gpu_req || gpu_gnt)
            starve_d = '0;
        else if (vga_gnt && starve_q != ST_W'(STARVE_MAX))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk_ir or negedge rst_sync_l) begin
        if (!rst_sync_l) begin
            tag_q      <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            cnt_q      <= '0;
            starve_q   <= '0;
            vga_v_q    <= 1'b0;
            gpu_v_q    <= 1'b0;
            vga_data_q <= '0;
            gpu_data_q <= '0;
            err_q      <= 1'b0;
        end else begin
            tag_q      <= tag_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            cnt_q      <= cnt_d;
            starve_q   <= starve_d;
            vga_v_q    <= vga_v_d;
            gpu_v_q    <= gpu_v_d;
            vga_data_q <= vga_data_d;
            gpu_data_q <= gpu_data_d;
            err_q      <= err_d;
        end
    end
endmodule

// File: tb/tb_syn_sram_arb.sv
// Directed bench for syn_sram_arb with a latency-2 SRAM driver model.
module tb_syn_sram_arb;
    logic clk;
    logic rst_n;
    logic auto_en;
    logic man_v;
    logic [15:0] man_d;
    logic p1_v, p2_v;
    logic [15:0] p1_d, p2_d;
    int n_chk;
    int n_pass;
    int n_fail;

    syn_sram_arb_if #(.ADDR_W(18), .DATA_W(16)) bus ();

    syn_sram_arb dut (
        .clk_ir     (clk),
        .rst_sync_l (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Driver model: read data appears two cycles after acceptance.
    always @(posedge clk) begin
        p1_v <= bus.sram_req & bus.sram_ready & ~bus.sram_wr;
        p1_d <= bus.sram_addr[15:0];
        p2_v <= p1_v;
        p2_d <= p1_d;
    end

    assign bus.sram_rd_valid = auto_en ? p2_v : man_v;
    assign bus.sram_rd_data  = auto_en ? p2_d : man_d;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_reqs();
        bus.vga_req     = 1'b0;
        bus.gpu_req     = 1'b0;
        bus.gpu_wr      = 1'b0;
        bus.vga_addr    = '0;
        bus.gpu_addr    = '0;
        bus.gpu_wr_data = '0;
    endtask

    initial begin
        n_chk = 0; n_pass = 0; n_fail = 0;
        p1_v = 0; p2_v = 0; p1_d = 0; p2_d = 0;
        auto_en = 1'b0; man_v = 1'b0; man_d = '0;
        rst_n = 1'b0;
        idle_reqs();
        bus.sram_ready = 1'b1;
        bus.vga_req  = 1'b1;
        bus.vga_addr = 18'h00055;
        #2;
        chk("rst_sram_req", bus.sram_req, 0);
        chk("rst_vga_gnt", bus.vga_gnt, 0);
        chk("rst_addr", bus.sram_addr, 0);
        chk("rst_vga_v", bus.vga_rd_valid, 0);
        chk("rst_gpu_data", bus.gpu_rd_data, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle_reqs();
        #1;
        chk("idle_sram_req", bus.sram_req, 0);
        chk("idle_gpu_gnt", bus.gpu_gnt, 0);

        // VGA-only reads through the auto driver
        auto_en = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            bus.vga_req  = (i < 4);
            bus.vga_addr = (i < 4) ? 18'(32'h10 + i) : '0;
            #1;
            if (i < 4) begin
                chk("t1_gnt", bus.vga_gnt, 1);
                chk("t1_addr", bus.sram_addr, 32'h10 + i);
            end
            chk("t1_vga_v", bus.vga_rd_valid, (i >= 3 && i <= 6));
            if (i >= 3 && i <= 6)
                chk("t1_vga_d", bus.vga_rd_data, 32'h10 + i - 3);
            chk("t1_gpu_v", bus.gpu_rd_valid, 0);
        end

        // Starvation guard with both clients held
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            bus.vga_req     = 1'b1;
            bus.vga_addr    = 18'h00400;
            bus.gpu_req     = 1'b1;
            bus.gpu_wr      = 1'b1;
            bus.gpu_addr    = 18'h02000;
            bus.gpu_wr_data = 16'h5A5A;
            #1;
            chk("t2_vga_gnt", bus.vga_gnt, (i != 8));
            chk("t2_gpu_gnt", bus.gpu_gnt, (i == 8));
            if (i == 8) begin
                chk("t2_wr", bus.sram_wr, 1);
                chk("t2_wdata", bus.sram_wr_data, 32'h5A5A);
            end
        end
        @(negedge clk);
        idle_reqs();
        repeat (4) @(negedge clk);
        auto_en = 1'b0;

        // Mixed interleave with manual returns
        @(negedge clk);
        bus.vga_req = 1'b1; bus.vga_addr = 18'h3FFFF;
        #1;
        chk("t3_g0", bus.vga_gnt, 1);
        chk("t3_a0", bus.sram_addr, 32'h3FFFF);
        @(negedge clk);
        bus.vga_req = 1'b0;
        bus.gpu_req = 1'b1; bus.gpu_wr = 1'b0; bus.gpu_addr = 18'h00000;
        #1;
        chk("t3_g1", bus.gpu_gnt, 1);
        chk("t3_wr1", bus.sram_wr, 0);
        @(negedge clk);
        bus.gpu_req = 1'b0;
        bus.vga_req = 1'b1; bus.vga_addr = 18'h12345;
        #1;
        chk("t3_g2", bus.vga_gnt, 1);
        @(negedge clk);
        idle_reqs();
        man_v = 1'b1; man_d = 16'hAAAA;
        @(negedge clk);
        man_d = 16'h5555;
        #1;
        chk("t3_v0", bus.vga_rd_valid, 1);
        chk("t3_d0", bus.vga_rd_data, 32'hAAAA);
        chk("t3_gv0", bus.gpu_rd_valid, 0);
        @(negedge clk);
        man_d = 16'h1234;
        #1;
        chk("t3_gv1", bus.gpu_rd_valid, 1);
        chk("t3_gd1", bus.gpu_rd_data, 32'h5555);
        chk("t3_v1", bus.vga_rd_valid, 0);
        @(negedge clk);
        man_v = 1'b0;
        #1;
        chk("t3_v2", bus.vga_rd_valid, 1);
        chk("t3_d2", bus.vga_rd_data, 32'h1234);
        @(negedge clk);
        #1;
        chk("t3_quiet", bus.vga_rd_valid | bus.gpu_rd_valid, 0);

        // Full tag FIFO
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            bus.vga_req = 1'b1; bus.vga_addr = 18'(32'h100 + i);
            #1;
            chk("t4_fill", bus.vga_gnt, 1);
        end
        @(negedge clk);
        bus.vga_addr = 18'h00104;
        #1;
        chk("t4_blk_gnt", bus.vga_gnt, 0);
        chk("t4_blk_req", bus.sram_req, 0);
        @(negedge clk);
        bus.vga_req = 1'b0;
        bus.gpu_req = 1'b1; bus.gpu_wr = 1'b1;
        bus.gpu_addr = 18'h00200; bus.gpu_wr_data = 16'hCAFE;
        #1;
        chk("t4_wr_gnt", bus.gpu_gnt, 1);
        chk("t4_wr_addr", bus.sram_addr, 32'h200);
        chk("t4_wr_data", bus.sram_wr_data, 32'hCAFE);
        @(negedge clk);
        idle_reqs();
        bus.vga_req = 1'b1; bus.vga_addr = 18'h00104;
        man_v = 1'b1; man_d = 16'hBEEF;
        #1;
        chk("t4_still_blk", bus.vga_gnt, 0);
        @(negedge clk);
        man_v = 1'b0;
        #1;
        chk("t4_unblk", bus.vga_gnt, 1);
        chk("t4_ret_v", bus.vga_rd_valid, 1);
        chk("t4_ret_d", bus.vga_rd_data, 32'hBEEF);
        @(negedge clk);
        idle_reqs();
        man_v = 1'b1;
        for (int i = 0; i < 4; i++) begin
            man_d = 16'(i);
            @(negedge clk);
        end
        man_v = 1'b0;
        @(negedge clk);

        // Backpressure: no grant, no push, address held on VGA
        bus.sram_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            bus.vga_req = 1'b1; bus.vga_addr = 18'h0ABCD;
            bus.gpu_req = 1'b1; bus.gpu_wr = 1'b0; bus.gpu_addr = 18'h01111;
            #1;
            chk("t5_vga_gnt", bus.vga_gnt, 0);
            chk("t5_gpu_gnt", bus.gpu_gnt, 0);
            chk("t5_req", bus.sram_req, 1);
            chk("t5_addr", bus.sram_addr, 32'h0ABCD);
            @(negedge clk);
        end
        idle_reqs();
        bus.sram_ready = 1'b1;
        man_v = 1'b1; man_d = 16'h7777;
        @(negedge clk);
        man_v = 1'b0;
        #1;
        chk("t5_no_tag", bus.vga_rd_valid | bus.gpu_rd_valid, 0);

        // Reset with three reads outstanding
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.vga_req = 1'b1; bus.vga_addr = 18'(32'h20 + i);
            #1;
            chk("t6_gnt", bus.vga_gnt, 1);
        end
        @(negedge clk);
        bus.gpu_req = 1'b1; bus.gpu_wr = 1'b1; bus.gpu_addr = 18'h00300;
        man_v = 1'b1; man_d = 16'h4444;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_req", bus.sram_req, 0);
        chk("t6_rst_wr", bus.sram_wr, 0);
        chk("t6_rst_gnt", bus.vga_gnt | bus.gpu_gnt, 0);
        chk("t6_rst_v", bus.vga_rd_valid | bus.gpu_rd_valid, 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle_reqs();
        man_d = 16'h9999;
        #1;
        chk("t6_post_req", bus.sram_req, 0);
        @(negedge clk);
        man_v = 1'b0;
        #1;
        chk("t6_late_v", bus.vga_rd_valid | bus.gpu_rd_valid, 0);
        chk("t6_late_d", bus.vga_rd_data, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
